// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the 8-bit ALU: accepts one instruction at a time,
// reads a 4-entry register file, drives registered ALU inputs, captures the result and retires it.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_z,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int          DEPTH  = 2 ** REG_AW;
    localparam logic [3:0]  OP_LI  = 4'b0000;
    localparam logic [3:0]  OP_ADD = 4'b0001;
    localparam logic [3:0]  OP_SUB = 4'b0010;
    localparam logic [3:0]  OP_NOR = 4'b0011;
    localparam logic [3:0]  OP_EQ  = 4'b0110;
    localparam logic [3:0]  OP_LT  = 4'b1000;
    localparam logic [3:0]  OP_SHL = 4'b1011;
    localparam logic [3:0]  OP_SHR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WB
    } state_t;

    state_t            state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] regs [DEPTH];

    logic [3:0]        op_q;
    logic [1:0]        rd_q;
    logic [1:0]        rs1_q;
    logic [1:0]        rs2_q;
    logic [7:0]        imm_q;

    assign op_q  = instr_q[15:12];
    assign rd_q  = instr_q[11:10];
    assign rs1_q = instr_q[9:8];
    assign rs2_q = instr_q[7:6];
    assign imm_q = instr_q[7:0];

    assign dbg_data = regs[dbg_addr];

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_EQ, OP_LT, OP_SHL, OP_SHR: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= 4'b0000;
            result      <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            // NOTE: the register file is small and must read as zero after reset,
            // so it is cleared here rather than left as an uninitialised RAM.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: done/err default low every cycle so they are true one-cycle pulses,
            // raised only on the edge that enters WB.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        if (instr[15:12] == OP_LI) begin
                            state <= WB;
                            done  <= 1'b1;
                        end else if (is_alu_op(instr[15:12])) begin
                            state <= ISSUE;
                        end else begin
                            state <= WB;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    alu_a   <= regs[rs1_q];
                    alu_b   <= regs[rs2_q];
                    alu_sel <= op_q;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    result <= alu_out;
                    flag_c <= alu_carry;
                    flag_z <= alu_z;
                    done   <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    // Operands were already read in ISSUE, so rd may alias rs1/rs2.
                    if (op_q == OP_LI) begin
                        regs[rd_q] <= DATA_W'(imm_q);
                        result     <= DATA_W'(imm_q);
                    end else if (is_alu_op(op_q)) begin
                        regs[rd_q] <= result;
                    end
                    alu_sel     <= 4'b0000;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
